// File: rtl/pll_seq_ctrl_if.sv
// Signal bundle between the PLL sequencing controller and the PLL / system side.
// The master modport is the controller; the slave modport is the PLL and reset consumers.
interface pll_seq_ctrl_if #(
    parameter int unsigned NUM_CLK = 3
);
    logic               pll_lock;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;
    logic               ready;
    logic               rst_out;
    logic [7:0]         retry_cnt;
    logic [7:0]         relock_cnt;
    logic               fault;

    modport master (
        input  pll_lock,
        output pll_reset, enclk, ready, rst_out, retry_cnt, relock_cnt, fault
    );

    modport slave (
        output pll_lock,
        input  pll_reset, enclk, ready, rst_out, retry_cnt, relock_cnt, fault
    );
endinterface

// File: rtl/pll_seq_ctrl.sv
// PLL bring-up and supervision controller: PLL reset pulse, filtered lock wait with
// timeout/retry, staggered clock enables, then system reset release.
// Optional macro PLL_SEQ_CTRL_RELOCK_EN: lock loss re-runs the full sequence instead of
// latching a sticky fault.
module pll_seq_ctrl #(
    parameter int unsigned NUM_CLK      = 3,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned EN_GAP       = 8
) (
    input logic            clkin,
    input logic            reset,
    pll_seq_ctrl_if.master bus
);
    localparam int unsigned EN_SPAN = NUM_CLK * EN_GAP;
    localparam int unsigned CNT_MAX = (RST_CYCLES > EN_SPAN) ? RST_CYCLES : EN_SPAN;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned SW      = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW      = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] EN_LAST   = CW'(EN_SPAN - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {StPrst, StWait, StEn, StRun, StFault} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      stab_q, stab_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [7:0]         retry_q, retry_d;
    logic [7:0]         relock_q, relock_d;
    logic               lock_m_q, lock_s_q;
    logic               pll_reset_q;
    logic [NUM_CLK-1:0] enclk_q, enclk_d;
    logic               ready_q;
    logic               rst_out_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            lock_m_q <= bus.pll_lock;
            lock_s_q <= lock_m_q;
        end
    end

    // State, counters and statistics registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q  <= StPrst;
            cnt_q    <= '0;
            stab_q   <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stab_q   <= stab_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
        end
    end

    // Next-state logic; every transition that enters a timed phase restarts cnt.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stab_d   = stab_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        unique case (state_q)
            StPrst: begin
                if (cnt_q == RST_LAST) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    stab_d  = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                stab_d = lock_s_q ? stab_q + 1'b1 : '0;
                tmo_d  = tmo_q + 1'b1;
                // Qualified lock takes priority over a simultaneous timeout.
                if (lock_s_q && (stab_q == STAB_LAST)) begin
                    state_d = StEn;
                    cnt_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StPrst;
                    cnt_d   = '0;
                    retry_d = sat_inc(retry_q);
                end
            end
            StEn, StRun: begin
                if (!lock_s_q) begin
                    relock_d = sat_inc(relock_q);
                    cnt_d    = '0;
`ifdef PLL_SEQ_CTRL_RELOCK_EN
                    state_d  = StPrst;
`else
                    state_d  = StFault;
`endif
                end else if (state_q == StEn) begin
                    if (cnt_q == EN_LAST) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StPrst;
                cnt_d   = '0;
            end
        endcase
    end

    // Enable k rises once the enable phase has run k gaps.
    always_comb begin
        enclk_d = '0;
        for (int unsigned k = 0; k < NUM_CLK; k++) begin
            enclk_d[k] = (state_d == StRun) ||
                         ((state_d == StEn) && (32'(cnt_d) >= k * EN_GAP));
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clkin) begin
        if (reset) begin
            pll_reset_q <= 1'b1;
            enclk_q     <= '0;
            ready_q     <= 1'b0;
            rst_out_q   <= 1'b1;
        end else begin
            pll_reset_q <= (state_d == StPrst);
            enclk_q     <= enclk_d;
            ready_q     <= (state_d == StRun);
            rst_out_q   <= (state_d != StRun);
        end
    end

`ifdef PLL_SEQ_CTRL_RELOCK_EN
    assign bus.fault = 1'b0;
`else
    logic fault_q;

    // Sticky lock-loss flag, cleared only by reset.
    always_ff @(posedge clkin) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == StFault);
        end
    end

    assign bus.fault = fault_q;
`endif

    assign bus.pll_reset  = pll_reset_q;
    assign bus.enclk      = enclk_q;
    assign bus.ready      = ready_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.relock_cnt = relock_q;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Scoreboard bench for pll_seq_ctrl: a phase-level model turns each lock waveform into a
// per-cycle expected trace; a negedge monitor pops and compares against the DUT.
module tb_pll_seq_ctrl;
    localparam int unsigned NUM_CLK      = 3;
    localparam int unsigned RST_CYCLES   = 4;
    localparam int unsigned LOCK_STABLE  = 8;
    localparam int unsigned LOCK_TIMEOUT = 64;
    localparam int unsigned EN_GAP       = 2;
    localparam int          MAXC         = 1023;
`ifdef PLL_SEQ_CTRL_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    typedef struct packed {
        logic       pll_reset;
        logic [2:0] enclk;
        logic       ready;
        logic       rst_out;
        logic [7:0] retry;
        logic [7:0] relock;
        logic       fault;
    } rec_t;

    logic clk = 1'b0;
    logic reset;

    pll_seq_ctrl_if #(.NUM_CLK(NUM_CLK)) bus ();

    pll_seq_ctrl #(
        .NUM_CLK      (NUM_CLK),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .EN_GAP       (EN_GAP)
    ) dut (
        .clkin (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit   lock_arr [0:MAXC];
    rec_t exp_arr  [0:MAXC];
    rec_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_tag  = 0;
    string run_name = "init";

    function automatic rec_t mk(input bit pr, input logic [2:0] en, input bit rdy,
                                input bit flt, input int rt, input int rl);
        rec_t r;
        r.pll_reset = pr;
        r.enclk     = en;
        r.ready     = rdy;
        r.rst_out   = !rdy;
        r.retry     = 8'(rt);
        r.relock    = 8'(rl);
        r.fault     = flt;
        return r;
    endfunction

    // Lock as seen by the controller: two cycles late, low right after reset.
    function automatic bit ls(input int c);
        if (c < 2 || c - 2 > MAXC) return 1'b0;
        return lock_arr[c-2];
    endfunction

    function automatic logic [2:0] en_mask(input int step);
        logic [2:0] m = '0;
        for (int k = 0; k < int'(NUM_CLK); k++) begin
            if (step >= k * int'(EN_GAP)) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic put(input int c, input int len, input rec_t r);
        if (c >= 0 && c <= len) exp_arr[c] = r;
    endtask

    // Phase model: reset pulse, search for LOCK_STABLE consecutive lock cycles inside the
    // timeout window, staggered enables until the first lost-lock cycle.
    task automatic build_model(input int len);
        int t, w, found, run, loss, step, retry, relock;
        t = 0; retry = 0; relock = 0;
        while (t <= len) begin
            for (int c = t; c < t + int'(RST_CYCLES); c++) put(c, len, mk(1, 3'b000, 0, 0, retry, relock));
            w = t + int'(RST_CYCLES);
            found = -1;
            run = 0;
            for (int c = w; c < w + int'(LOCK_TIMEOUT); c++) begin
                put(c, len, mk(0, 3'b000, 0, 0, retry, relock));
                run = ls(c) ? run + 1 : 0;
                if (run == int'(LOCK_STABLE)) begin
                    found = c;
                    break;
                end
            end
            if (found < 0) begin
                retry = sat(retry);
                t = w + int'(LOCK_TIMEOUT);
                continue;
            end
            loss = -1;
            for (int n = found + 1; n <= len; n++) begin
                step = n - found - 1;
                put(n, len, mk(0, en_mask(step), step >= int'(NUM_CLK * EN_GAP), 0, retry, relock));
                if (!ls(n)) begin
                    loss = n;
                    break;
                end
            end
            if (loss < 0) break;
            relock = sat(relock);
            if (RELOCK) begin
                t = loss + 1;
            end else begin
                for (int c = loss + 1; c <= len; c++) put(c, len, mk(0, 3'b000, 0, 1, retry, relock));
                break;
            end
        end
    endtask

    // Drive one run: cycles 0..len-1 out of reset, reset asserted from cycle len for 3 cycles.
    task automatic do_run(input string name, input int len);
        build_model(len);
        run_name = name;
        for (int c = 0; c <= len + 2; c++) begin
            reset    = (c >= len);
            bus.pll_lock = (c < len) ? lock_arr[c] : 1'b1;
            cyc_tag  = c;
            if (c <= len) sb_q.push_back(exp_arr[c]);
            else          sb_q.push_back(mk(1, 3'b000, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_lock(input bit v);
        for (int c = 0; c <= MAXC; c++) lock_arr[c] = v;
    endtask

    always @(negedge clk) begin
        rec_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {bus.pll_reset, bus.enclk, bus.ready, bus.rst_out,
                 bus.retry_cnt, bus.relock_cnt, bus.fault};
            n_checks++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s cyc %0d: got prst=%b en=%b rdy=%b rst=%b rt=%0d rl=%0d f=%b, want prst=%b en=%b rdy=%b rst=%b rt=%0d rl=%0d f=%b",
                         run_name, cyc_tag, a.pll_reset, a.enclk, a.ready, a.rst_out, a.retry,
                         a.relock, a.fault, e.pll_reset, e.enclk, e.ready, e.rst_out, e.retry,
                         e.relock, e.fault);
            end
        end
    end

    initial begin
        int len, low_for, gp;
        reset = 1'b1;
        bus.pll_lock = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cyc_tag = i;
            sb_q.push_back(mk(1, 3'b000, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end

        fill_lock(1'b1);
        do_run("clean", 40);

        fill_lock(1'b1);
        for (int c = 0; c < 200; c++) lock_arr[c] = 1'b0;
        do_run("timeout", 240);

        for (int c = 0; c <= MAXC; c++) lock_arr[c] = (c % 6) != 5;
        do_run("stability", 150);

        fill_lock(1'b1);
        lock_arr[30] = 1'b0;
        do_run("lockloss", 70);

        fill_lock(1'b1);
        do_run("clean_again", 30);

        fill_lock(1'b1);
        do_run("midreset", 15);

        for (int r = 0; r < 6; r++) begin
            len     = int'($urandom_range(120, 400));
            low_for = int'($urandom_range(0, 150));
            gp      = int'($urandom_range(0, 3));
            for (int c = 0; c <= MAXC; c++) begin
                lock_arr[c] = (c >= low_for) && (int'($urandom_range(0, 99)) >= gp);
            end
            do_run($sformatf("random%0d", r), len);
        end

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pll_seq_ctrl.md
# pll_seq_ctrl

Parametrised PLL bring-up and supervision controller for the Gowin PLL wrappers. It drives the PLL reset, qualifies `lock` with a stability filter and timeout/retry, then raises up to seven clock-output enables one at a time with a fixed gap. Once all enables are up it releases a system reset. It runs on the PLL reference clock, sits between the board clock input and the PLL instance, and gates the DDR, core and video clock domains.

## Interface
Parameters:
- `NUM_CLK`, 3: number of `enclk` channels driven (1..7).
- `RST_CYCLES`, 16: PLL reset pulse length, in cycles (>=1).
- `LOCK_STABLE`, 256: consecutive synchronised lock-high cycles required (>=1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in lock wait before a retry (> `LOCK_STABLE`).
- `EN_GAP`, 8: cycles between successive enable rises, and from the last enable to `ready` (>=1).

Ports:
- `clkin` in 1: reference clock. All logic runs on this single clock.
- `reset` in 1: synchronous, active-high.
- `pll_lock` in 1: raw PLL `lock`, asynchronous to `clkin`.
- `pll_reset` out 1: drives PLL `RESET`.
- `enclk` out `NUM_CLK`: drives PLL `ENCLK0..NUM_CLK-1`.
- `ready` out 1: all clocks enabled and stable.
- `rst_out` out 1: system reset, always equal to `!ready`.
- `retry_cnt` out 8: count of lock-wait timeouts, saturating at 255.
- `relock_cnt` out 8: count of lock losses after qualification, saturating at 255.
- `fault` out 1: sticky lock-loss flag. Used only without the macro.

## Operation
- `pll_lock` passes through a 2-flop synchroniser to give `lock_s`; this adds 2 cycles of latency.
- All outputs are registered.
- Reset values: `pll_reset`=1, `enclk`=0, `ready`=0, `rst_out`=1, `retry_cnt`=0, `relock_cnt`=0, `fault`=0, state=S_PRST, all counters=0.
- **S_PRST**
  - `pll_reset`=1, `enclk`=0.
  - `cnt` increments each cycle.
  - At `cnt`==`RST_CYCLES`-1, go to S_WAIT and clear the counters.
- **S_WAIT**
  - `pll_reset`=0.
  - `stab` increments while `lock_s`=1 and clears to 0 when `lock_s`=0.
  - `tmo` increments every cycle.
  - If `stab`==`LOCK_STABLE`-1 and `lock_s`=1, go to S_EN.
  - Else if `tmo`==`LOCK_TIMEOUT`-1, go to S_PRST and increment `retry_cnt`.
  - If both conditions hold in the same cycle, the lock wins.
- **S_EN**
  - With N the first cycle in S_EN, `enclk[k]` is 1 from cycle N+k·`EN_GAP`.
  - At N+`NUM_CLK`·`EN_GAP`, go to S_RUN.
- **S_RUN**
  - `ready`=1 and `rst_out`=0.
  - All enables stay high.
- **Lock loss** (`lock_s`=0 while in S_EN or S_RUN), on the next cycle:
  - `enclk`=0, `ready`=0, `rst_out`=1.
  - `relock_cnt` increments (saturating).
  - The state transition depends on the Configuration macro.
- **S_FAULT**
  - `pll_reset`=0, `enclk`=0, `ready`=0.
  - `fault`=1.
  - Only `reset` exits this state.
- `reset` asserted mid-sequence in any state returns every output to its reset value on the next edge. There is no partial state retention.
- Counter widths are `$clog2` of the respective parameter. None of them wrap while in use.
- The saturating counters hold at 255.

## Timing
- `pll_reset` stays high for exactly `RST_CYCLES` cycles after `reset` falls.
- If `pll_lock` is high throughout, S_EN is entered at N=`RST_CYCLES`+`LOCK_STABLE` cycles after `reset` release.
  - The 2-cycle synchroniser latency is hidden as long as the lock arrives during S_PRST with `RST_CYCLES`>=2.
- `ready` rises at N+`NUM_CLK`·`EN_GAP`.
- Lock-loss response: `enclk` falls 3 cycles after `pll_lock` falls (2 synchroniser cycles plus 1 registered output).
- A single-cycle glitch on `pll_lock` during S_WAIT restarts `stab` but does not touch `tmo`.

## Configuration
- Macro: `PLL_SEQ_CTRL_RELOCK_EN`.
- Defined: a lock loss goes to S_PRST and runs the full re-sequence automatically. `fault` is tied to 0.
- Undefined: a lock loss goes to S_FAULT and sets `fault`=1 until `reset`. `relock_cnt` still counts, with a maximum of 1 per reset.

## Test plan
Common parameters for all scenarios: `NUM_CLK`=3, `RST_CYCLES`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=64, `EN_GAP`=2.

- **Clean bring-up.** Hold `pll_lock`=1 from reset release.
  - `pll_reset` is high during cycles 0-3.
  - `enclk` reads 001 at cycle 12, 011 at 14 and 111 at 16.
  - `ready`=1 and `rst_out`=0 at cycle 18.
- **Timeout retry.** Hold `pll_lock`=0 for 200 cycles, then 1.
  - `retry_cnt`=2 after 2×(4+64) cycles, then 3 after the third window (cycle 204).
  - The sequence then completes normally in the fourth lock wait, after the lock rises at 200.
- **Stability filter.** In S_WAIT, toggle `pll_lock` low for 1 cycle every 6 cycles.
  - S_EN is never entered.
  - A timeout occurs and `retry_cnt` increments.
- **Lock loss in S_RUN, macro defined.** Drop `pll_lock` for 1 cycle.
  - `enclk`=000 and `ready`=0 three cycles later.
  - `relock_cnt`=1.
  - `ready` returns 18 cycles after S_PRST entry.
- **Lock loss in S_RUN, macro undefined.** Drop `pll_lock` for 1 cycle.
  - `fault`=1 and the block stays in S_FAULT with `lock` high.
  - Asserting `reset` clears `fault`, and the clean bring-up timing repeats.
- **Mid-sequence reset.** Assert `reset` at cycle 15 (`enclk`=011).
  - On the next edge: `enclk`=000, `pll_reset`=1, counters and saturating counts cleared.
